// File: rtl/adc_pkg.sv
// adc_pkg: shared tags, FSM state type and word-formatting helpers for the
// ADC frame packer.
//   HDR_TAG / DATA_TAG : upper-nibble tags on header and data words
//   packer_state_t     : packer FSM states
//   make_header()      : {HDR_TAG, channel, 8'h00, frame_count}
//   make_data_word()   : {DATA_TAG, 4'h0, s1, channel, s0}
package adc_pkg;

  localparam logic [3:0] HDR_TAG  = 4'hA;
  localparam logic [3:0] DATA_TAG = 4'hD;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    RD0,
    CAP0,
    RD1,
    CAP1,
    SEND
  } packer_state_t;

  function automatic logic [31:0] make_header(input logic [3:0]  ch,
                                              input logic [15:0] fc);
    return {HDR_TAG, ch, 8'h00, fc};
  endfunction

  function automatic logic [31:0] make_data_word(input logic [3:0]  ch,
                                                 input logic [11:0] s1,
                                                 input logic [11:0] s0);
    return {DATA_TAG, 4'h0, s1, ch, s0};
  endfunction

endpackage

// File: rtl/adc_frame_packer.sv
// adc_frame_packer: drains 12-bit samples from a non-FWFT FIFO (read latency 1)
// and emits fixed-length frames on an AXI4-Stream master. Each frame is one
// header word followed by FRAME_SAMPLES/2 data words, two samples per word.
// Ports:
//   clk, rst                  FIFO read clock, async active-high reset
//   enable                    permits a new frame (sampled only in IDLE)
//   fifo_not_empty, fifo_dout FIFO status and read data
//   fifo_rd_en                FIFO read strobe
//   m_axis_tdata/tvalid/tready/tlast  stream master
//   frame_count               frames fully accepted downstream (wraps)
//   busy                      FSM not in IDLE
module adc_frame_packer
  import adc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 12,
  parameter int unsigned FRAME_SAMPLES = 256,
  parameter logic [3:0]  CHANNEL_ID    = 4'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_not_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [15:0]           frame_count,
  output logic                  busy
);

  localparam int unsigned PAIRS = FRAME_SAMPLES / 2;
  localparam int unsigned PW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  packer_state_t r_state;
  packer_state_t w_next;
  logic [PW-1:0] r_pair;
  logic [11:0]   r_s0;
  logic [11:0]   r_s1;
  logic [15:0]   r_frame_count;
  logic [11:0]   w_sample;
  logic          w_last_pair;

  assign w_sample    = 12'(fifo_dout);
  assign w_last_pair = (r_pair == PW'(PAIRS - 1));
  assign frame_count = r_frame_count;
  assign busy        = (r_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pair        <= '0;
      r_s0          <= '0;
      r_s1          <= '0;
      r_frame_count <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: r_pair <= '0;
        CAP0: r_s0   <= w_sample;
        CAP1: r_s1   <= w_sample;
        SEND: begin
          if (m_axis_tready) begin
            r_pair <= r_pair + 1'b1;
            if (w_last_pair) r_frame_count <= r_frame_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state and stable registers only, so tdata/tlast
  // cannot move while a word is stalled.
  always_comb begin
    w_next        = r_state;
    fifo_rd_en    = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    case (r_state)
      IDLE: if (enable) w_next = HDR;
      HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = make_header(CHANNEL_ID, r_frame_count);
        if (m_axis_tready) w_next = RD0;
      end
      RD0: begin
        if (fifo_not_empty) begin
          fifo_rd_en = 1'b1;
          w_next     = CAP0;
        end
      end
      CAP0: w_next = RD1;
      RD1: begin
        if (fifo_not_empty) begin
          fifo_rd_en = 1'b1;
          w_next     = CAP1;
        end
      end
      CAP1: w_next = SEND;
      SEND: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = make_data_word(CHANNEL_ID, r_s1, r_s0);
        m_axis_tlast  = w_last_pair;
        if (m_axis_tready) w_next = w_last_pair ? IDLE : RD0;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// tb_adc_frame_packer: directed sequence with randomized data and backpressure,
// checked against a frame-level reference built from the sample stream.
// Two instances: u_d0 (CHANNEL_ID 0, 256 samples/frame) and u_d5
// (CHANNEL_ID 5, 4 samples/frame); 'sel' chooses which one is driven/observed.
module tb_adc_frame_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        fne = 1'b0;
  logic        sel = 1'b0;
  logic        tready = 1'b1;
  logic [11:0] fifo_dout = '0;

  logic        rd0, tv0, tl0, bz0, rd5, tv5, tl5, bz5;
  logic [31:0] td0, td5;
  logic [15:0] fc0, fc5;

  logic        w_rd, w_tvalid, w_tlast, w_busy;
  logic [31:0] w_tdata;
  logic [15:0] w_fc;

  always #5 clk = ~clk;

  adc_frame_packer #(.DATA_WIDTH(12), .FRAME_SAMPLES(256), .CHANNEL_ID(4'd0)) u_d0 (
    .clk(clk), .rst(rst), .enable(enable & ~sel), .fifo_not_empty(fne & ~sel),
    .fifo_dout(fifo_dout), .fifo_rd_en(rd0), .m_axis_tdata(td0),
    .m_axis_tvalid(tv0), .m_axis_tready(tready), .m_axis_tlast(tl0),
    .frame_count(fc0), .busy(bz0));

  adc_frame_packer #(.DATA_WIDTH(12), .FRAME_SAMPLES(4), .CHANNEL_ID(4'd5)) u_d5 (
    .clk(clk), .rst(rst), .enable(enable & sel), .fifo_not_empty(fne & sel),
    .fifo_dout(fifo_dout), .fifo_rd_en(rd5), .m_axis_tdata(td5),
    .m_axis_tvalid(tv5), .m_axis_tready(tready), .m_axis_tlast(tl5),
    .frame_count(fc5), .busy(bz5));

  assign w_rd     = sel ? rd5 : rd0;
  assign w_tdata  = sel ? td5 : td0;
  assign w_tvalid = sel ? tv5 : tv0;
  assign w_tlast  = sel ? tl5 : tl0;
  assign w_fc     = sel ? fc5 : fc0;
  assign w_busy   = sel ? bz5 : bz0;

  int          checks = 0;
  int          errors = 0;
  int          ready_mode = 0;  // 0: always ready, 1: random, 2: never
  logic [31:0] exp_d[$];
  logic        exp_l[$];
  logic [11:0] src_q[$];
  logic [11:0] fifo_q[$];
  logic [11:0] ref_q[$];
  logic [15:0] m_fc = '0;
  logic        prev_stall = 1'b0;
  logic        prev_rd = 1'b0;
  logic [31:0] prev_d = '0;
  logic        prev_l = 1'b0;
  logic [1:0]  bhist = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_seq(input int n);
    for (int i = 1; i <= n; i++) begin
      src_q.push_back(12'(i));
      ref_q.push_back(12'(i));
    end
  endtask

  task automatic load_rand(input int n);
    logic [11:0] s;
    for (int i = 0; i < n; i++) begin
      s = 12'($urandom_range(0, 4095));
      src_q.push_back(s);
      ref_q.push_back(s);
    end
  endtask

  task automatic release_n(input int n);
    for (int i = 0; i < n; i++)
      if (src_q.size() != 0) fifo_q.push_back(src_q.pop_front());
    fne = (fifo_q.size() != 0);
  endtask

  // Reference frame: header from the model frame count, then samples paired
  // in arrival order, earlier sample in the low field.
  task automatic expect_frame(input logic [3:0] ch, input int pairs);
    logic [11:0] s0, s1;
    exp_d.push_back({4'hA, ch, 8'h00, m_fc});
    exp_l.push_back(1'b0);
    for (int p = 0; p < pairs; p++) begin
      s0 = ref_q.pop_front();
      s1 = ref_q.pop_front();
      exp_d.push_back({4'hD, 4'h0, s1, ch, s0});
      exp_l.push_back(p == pairs - 1);
    end
    m_fc = m_fc + 16'd1;
  endtask

  task automatic step();
    logic [31:0] ed;
    logic        el;
    @(negedge clk);
    chk("rd_while_empty", w_rd & ~fne, 1'b0);
    chk("rd_back_to_back", w_rd & prev_rd, 1'b0);
    chk("tvalid_during_rd", w_rd & w_tvalid, 1'b0);
    if (prev_stall) begin
      chk("stall_tvalid", w_tvalid, 1'b1);
      chk("stall_tdata", w_tdata, prev_d);
      chk("stall_tlast", w_tlast, prev_l);
    end
    if (w_tvalid && tready) begin
      if (exp_d.size() == 0) begin
        chk("unexpected_word", w_tdata, 32'h0);
      end else begin
        ed = exp_d.pop_front();
        el = exp_l.pop_front();
        chk("tdata", w_tdata, ed);
        chk("tlast", w_tlast, el);
      end
    end
    prev_stall = w_tvalid & ~tready;
    prev_d     = w_tdata;
    prev_l     = w_tlast;
    prev_rd    = w_rd;
    bhist      = {bhist[0], w_busy};
    @(posedge clk);
    #1;
    if (prev_rd && fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
    case (ready_mode)
      1:       tready = 1'($urandom_range(0, 1));
      2:       tready = 1'b0;
      default: tready = 1'b1;
    endcase
    fne = (fifo_q.size() != 0);
  endtask

  task automatic run_frame(input bit hold_en, input int budget);
    int n = 0;
    int start_sz = exp_d.size();
    while (exp_d.size() != 0 && n < budget) begin
      step();
      n++;
      if (!hold_en && exp_d.size() < start_sz) enable = 1'b0;
    end
    chk("frame_timeout_words_left", exp_d.size(), 0);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", w_tvalid, 1'b0);
    chk("rst_tdata", w_tdata, 32'h0);
    chk("rst_tlast", w_tlast, 1'b0);
    chk("rst_rd_en", w_rd, 1'b0);
    chk("rst_frame_count", w_fc, 16'h0);
    chk("rst_busy", w_busy, 1'b0);
    rst = 1'b0;

    // 1: ramp 0x001..0x100, always ready, enable dropped after header
    load_seq(256);
    release_n(256);
    expect_frame(4'd0, 128);
    enable = 1'b1;
    run_frame(1'b0, 2000);
    chk("frame_count_after_1", w_fc, m_fc);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_after_frame_busy", w_busy, 1'b0);
      chk("idle_after_frame_tvalid", w_tvalid, 1'b0);
    end

    // 2: same data under random backpressure
    load_seq(256);
    release_n(256);
    expect_frame(4'd0, 128);
    ready_mode = 1;
    enable = 1'b1;
    run_frame(1'b0, 4000);
    chk("frame_count_after_2", w_fc, m_fc);
    ready_mode = 0;
    step();

    // 3: FIFO starves after 3 samples, refilled 40 cycles later
    load_rand(256);
    release_n(3);
    expect_frame(4'd0, 128);
    enable = 1'b1;
    repeat (20) step();
    enable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("starve_tvalid", w_tvalid, 1'b0);
      chk("starve_rd_en", w_rd, 1'b0);
      chk("starve_busy", w_busy, 1'b1);
    end
    release_n(253);
    run_frame(1'b0, 2000);
    chk("frame_count_after_3", w_fc, m_fc);

    // 4: reset while stalled in SEND mid-frame
    load_rand(256);
    release_n(256);
    expect_frame(4'd0, 128);
    enable = 1'b1;
    n = 0;
    while (exp_d.size() > 126 && n < 100) begin
      step();
      n++;
    end
    enable = 1'b0;
    ready_mode = 2;
    tready = 1'b0;
    n = 0;
    while (!w_tvalid && n < 20) begin
      step();
      n++;
    end
    chk("reached_send", w_tvalid, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_tvalid", w_tvalid, 1'b0);
    chk("midrst_tdata", w_tdata, 32'h0);
    chk("midrst_tlast", w_tlast, 1'b0);
    chk("midrst_rd_en", w_rd, 1'b0);
    chk("midrst_frame_count", w_fc, 16'h0);
    chk("midrst_busy", w_busy, 1'b0);
    exp_d.delete();
    exp_l.delete();
    src_q.delete();
    fifo_q.delete();
    ref_q.delete();
    m_fc = '0;
    prev_stall = 1'b0;
    prev_rd = 1'b0;
    fne = 1'b0;
    ready_mode = 0;
    tready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    load_rand(256);
    release_n(256);
    expect_frame(4'd0, 128);
    enable = 1'b1;
    run_frame(1'b0, 2000);
    chk("frame_count_after_rst", w_fc, m_fc);

    // 5: CHANNEL_ID 5 instance, frame_count wrap and back-to-back frames
    sel = 1'b1;
    step();
    force u_d5.r_frame_count = 16'hFFFF;
    @(posedge clk);
    #1;
    release u_d5.r_frame_count;
    step();
    chk("forced_frame_count", w_fc, 16'hFFFF);
    m_fc = 16'hFFFF;
    load_rand(8);
    release_n(8);
    expect_frame(4'd5, 2);
    ready_mode = 1;
    enable = 1'b1;
    run_frame(1'b1, 200);
    chk("frame_count_wrap", w_fc, 16'h0000);
    expect_frame(4'd5, 2);
    ready_mode = 0;
    tready = 1'b1;
    step();
    step();
    chk("idle_gap_one_cycle", bhist, 2'b01);
    enable = 1'b0;
    run_frame(1'b0, 200);
    chk("frame_count_b2b", w_fc, m_fc);
    step();
    chk("final_busy", w_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
